// File: rtl/hms_pkg.sv
// Shared widths, limits and helpers for the HH:MM:SS time-of-day clock.
package hms_pkg;

  localparam int HR_W    = 5;
  localparam int MS_W    = 6;
  localparam int MIN_MAX = 59;
  localparam int HR_MAX  = 23;

  typedef struct packed {
    logic [HR_W-1:0] hours;
    logic [MS_W-1:0] mins;
    logic [MS_W-1:0] secs;
  } hms_t;

  // Returns {pm, hours_disp} for 12-hour display; midnight and noon both show 12.
  function automatic logic [HR_W:0] to_12h(input logic [HR_W-1:0] hours);
    logic            pm;
    logic [HR_W-1:0] disp;
    pm = (hours >= HR_W'(12));
    if (hours == '0)
      disp = HR_W'(12);
    else if (hours > HR_W'(12))
      disp = hours - HR_W'(12);
    else
      disp = hours;
    return {pm, disp};
  endfunction

endpackage

// File: rtl/hms_clock_counter.sv
// Modulo-(N+1) counter with synchronous load; wrap is the carry into the next stage.
module mod_n_counter #(
  parameter int N = 59,
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  output logic [W-1:0] q,
  output logic         wrap
);

  localparam logic [W-1:0] MAXV = W'(N);

  assign wrap = en && (q == MAXV);

  // Load wins over count; an out-of-range load value lands on zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      q <= '0;
    else if (ld)
      q <= (ld_val > MAXV) ? '0 : ld_val;
    else if (en)
      q <= (q == MAXV) ? '0 : q + W'(1);
  end

endmodule

// File: rtl/hms_clock.sv
// HH:MM:SS time-of-day clock with prescaler, run/stop, load, 12/24-h display,
// alarm match and day-rollover pulses.
module hms_clock
  import hms_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int SEC_MAX  = 59
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic            load,
  input  logic [HR_W-1:0] load_h,
  input  logic [MS_W-1:0] load_m,
  input  logic [MS_W-1:0] load_s,
  input  logic            mode_12h,
  input  logic            alarm_en,
  input  logic [HR_W-1:0] alarm_h,
  input  logic [MS_W-1:0] alarm_m,
  output logic [HR_W-1:0] hours,
  output logic [MS_W-1:0] mins,
  output logic [MS_W-1:0] secs,
  output logic [HR_W-1:0] hours_disp,
  output logic            pm,
  output logic            sec_tick,
  output logic            alarm_hit,
  output logic            day_tick
);

  localparam int            PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  logic [PW-1:0] pcnt;
  logic          tick;
  logic          s_wrap, m_wrap, h_wrap;
  logic          hit_d;
  hms_t          nxt;

  // A load in the same cycle swallows the tick and restarts the prescaler phase.
  assign tick = run && !load && (pcnt == PMAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pcnt <= '0;
    else if (load)
      pcnt <= '0;
    else if (run)
      pcnt <= tick ? '0 : pcnt + PW'(1);
  end

  mod_n_counter #(.N(SEC_MAX), .W(MS_W)) u_secs (
    .clk(clk), .rst(rst), .en(tick), .ld(load), .ld_val(load_s),
    .q(secs), .wrap(s_wrap)
  );

  mod_n_counter #(.N(MIN_MAX), .W(MS_W)) u_mins (
    .clk(clk), .rst(rst), .en(s_wrap), .ld(load), .ld_val(load_m),
    .q(mins), .wrap(m_wrap)
  );

  mod_n_counter #(.N(HR_MAX), .W(HR_W)) u_hours (
    .clk(clk), .rst(rst), .en(m_wrap), .ld(load), .ld_val(load_h),
    .q(hours), .wrap(h_wrap)
  );

  // Time after a minute rollover; the alarm only fires on the :00 second of its minute.
  always_comb begin
    nxt       = '0;
    nxt.mins  = m_wrap ? '0 : mins + MS_W'(1);
    nxt.hours = h_wrap ? '0 : (m_wrap ? hours + HR_W'(1) : hours);
    hit_d     = s_wrap && alarm_en && (nxt.hours == alarm_h) && (nxt.mins == alarm_m);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sec_tick  <= 1'b0;
      alarm_hit <= 1'b0;
      day_tick  <= 1'b0;
    end else begin
      sec_tick  <= tick;
      alarm_hit <= hit_d;
      day_tick  <= h_wrap;
    end
  end

  assign {pm, hours_disp} = mode_12h ? to_12h(hours) : {hours >= HR_W'(12), hours};

endmodule

// File: tb/tb_hms_clock.sv
// Bench for hms_clock: two instances (TICK_DIV 4 and 1) share stimulus and are
// scored every cycle against a seconds-of-day reference model.
module tb_hms_clock;
  import hms_pkg::*;

  localparam int VW = 20;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            run = 1'b0, load = 1'b0, mode_12h = 1'b0, alarm_en = 1'b0;
  logic [HR_W-1:0] load_h = '0, alarm_h = '0;
  logic [MS_W-1:0] load_m = '0, load_s = '0, alarm_m = '0;

  logic [HR_W-1:0] h4, d4, h1, d1;
  logic [MS_W-1:0] m4, s4, m1, s1;
  logic            pm4, st4, ah4, dt4, pm1, st1, ah1, dt1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [2*VW-1:0] exp_q[$];

  always #5 clk = ~clk;

  hms_clock #(.TICK_DIV(4), .SEC_MAX(59)) u4 (
    .clk(clk), .rst(rst), .run(run), .load(load), .load_h(load_h), .load_m(load_m),
    .load_s(load_s), .mode_12h(mode_12h), .alarm_en(alarm_en), .alarm_h(alarm_h),
    .alarm_m(alarm_m), .hours(h4), .mins(m4), .secs(s4), .hours_disp(d4), .pm(pm4),
    .sec_tick(st4), .alarm_hit(ah4), .day_tick(dt4)
  );

  hms_clock #(.TICK_DIV(1), .SEC_MAX(59)) u1 (
    .clk(clk), .rst(rst), .run(run), .load(load), .load_h(load_h), .load_m(load_m),
    .load_s(load_s), .mode_12h(mode_12h), .alarm_en(alarm_en), .alarm_h(alarm_h),
    .alarm_m(alarm_m), .hours(h1), .mins(m1), .secs(s1), .hours_disp(d1), .pm(pm1),
    .sec_tick(st1), .alarm_hit(ah1), .day_tick(dt1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model: time kept as seconds since midnight
  typedef struct { int t; int pc; bit st; bit ah; bit dt; } mstate_t;
  mstate_t ms[2];

  function automatic mstate_t model_step(input mstate_t s, input int div);
    mstate_t n;
    int hh, mm, ss;
    n = s;
    n.st = 0; n.ah = 0; n.dt = 0;
    if (load) begin
      hh = (int'(load_h) <= 23) ? int'(load_h) : 0;
      mm = (int'(load_m) <= 59) ? int'(load_m) : 0;
      ss = (int'(load_s) <= 59) ? int'(load_s) : 0;
      n.t  = hh * 3600 + mm * 60 + ss;
      n.pc = 0;
    end else if (run) begin
      if (s.pc == div - 1) begin
        n.pc = 0;
        n.t  = (s.t + 1) % 86400;
        n.st = 1;
        n.dt = (n.t == 0);
        n.ah = alarm_en && (int'(alarm_h) < 24) && (int'(alarm_m) < 60) &&
               (n.t == int'(alarm_h) * 3600 + int'(alarm_m) * 60);
      end else begin
        n.pc = s.pc + 1;
      end
    end
    return n;
  endfunction

  function automatic logic [VW-1:0] model_pack(input mstate_t s);
    return {5'(s.t / 3600), 6'((s.t / 60) % 60), 6'(s.t % 60), s.st, s.ah, s.dt};
  endfunction

  function automatic logic [5:0] disp_ref(input int h, input logic m12);
    int d;
    d = m12 ? ((h % 12 == 0) ? 12 : h % 12) : h;
    return {(h >= 12) ? 1'b1 : 1'b0, 5'(d)};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ms[0] <= '{default: 0};
      ms[1] <= '{default: 0};
      exp_q.delete();
      exp_q.push_back('0);
    end else begin
      ms[0] <= model_step(ms[0], 4);
      ms[1] <= model_step(ms[1], 1);
      exp_q.push_back({model_pack(model_step(ms[0], 4)), model_pack(model_step(ms[1], 1))});
    end
  end

  // ---------------- scoreboard
  always @(negedge clk) begin : sb
    logic [2*VW-1:0] v;
    if (exp_q.size() > 0) begin
      v = exp_q.pop_front();
      check("sb_u4", {h4, m4, s4, st4, ah4, dt4}, v[2*VW-1:VW]);
      check("sb_u1", {h1, m1, s1, st1, ah1, dt1}, v[VW-1:0]);
      check("sb_disp_u4", {pm4, d4}, disp_ref(int'(v[2*VW-1 -: 5]), mode_12h));
      check("sb_disp_u1", {pm1, d1}, disp_ref(int'(v[VW-1 -: 5]), mode_12h));
    end
  end

  // ---------------- driver tasks (inputs change 2 time units after a rising edge)
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_load(input int hh, input int mm, input int ss);
    load_h = 5'(hh); load_m = 6'(mm); load_s = 6'(ss);
    load = 1'b1;
    step(1);
    load = 1'b0;
  endtask

  int hits;
  int tab_h[3]  = '{0, 12, 13};
  int tab_m[3]  = '{0, 0, 5};
  int tab_d[3]  = '{12, 12, 1};
  int tab_pm[3] = '{0, 1, 1};

  initial begin
    // reset state in both display modes
    mode_12h = 1'b1;
    step(3);
    check("rst_time", {h4, m4, s4, h1, m1, s1}, '0);
    check("rst_pulses", {st4, ah4, dt4, st1, ah1, dt1}, '0);
    check("rst_disp12", {pm4, d4}, {1'b0, 5'd12});
    mode_12h = 1'b0;
    #1 check("rst_disp24", {pm4, d4}, '0);

    // free-running count
    rst = 1'b0; run = 1'b1;
    step(3);
    check("first_tick_early", {st4, s4}, {1'b0, 6'd0});
    step(1);
    check("first_tick", {st4, s4}, {1'b1, 6'd1});
    step(236);
    check("u4_240cyc", {h4, m4, s4}, {5'd0, 6'd1, 6'd0});
    check("u1_240cyc", {h1, m1, s1}, {5'd0, 6'd4, 6'd0});

    // day rollover
    do_load(23, 59, 58);
    check("roll_load", {h1, m1, s1, st1, dt1}, {5'd23, 6'd59, 6'd58, 1'b0, 1'b0});
    step(1);
    check("roll_59", {h1, m1, s1, dt1}, {5'd23, 6'd59, 6'd59, 1'b0});
    step(1);
    check("roll_wrap", {h1, m1, s1, dt1}, {5'd0, 6'd0, 6'd0, 1'b1});
    step(1);
    check("roll_after", {h1, m1, s1, dt1}, {5'd0, 6'd0, 6'd1, 1'b0});

    // load colliding with the internal tick
    do_load(1, 2, 3);
    step(3);
    do_load(12, 34, 56);
    check("ldpri_time", {h4, m4, s4, st4}, {5'd12, 6'd34, 6'd56, 1'b0});
    step(3);
    check("ldpri_hold", {s4, st4}, {6'd56, 1'b0});
    step(1);
    check("ldpri_next", {h4, m4, s4, st4}, {5'd12, 6'd34, 6'd57, 1'b1});
    do_load(24, 60, 61);
    check("ld_oor_u4", {h4, m4, s4}, '0);
    check("ld_oor_u1", {h1, m1, s1}, '0);

    // alarm
    alarm_h = 5'd7; alarm_m = 6'd30; alarm_en = 1'b1;
    do_load(7, 29, 58);
    step(1);
    check("alarm_pre", {h1, m1, s1, ah1}, {5'd7, 6'd29, 6'd59, 1'b0});
    step(1);
    check("alarm_hit", {h1, m1, s1, ah1}, {5'd7, 6'd30, 6'd0, 1'b1});
    step(1);
    check("alarm_post", ah1, 1'b0);
    alarm_en = 1'b0;
    do_load(7, 29, 58);
    hits = 0;
    repeat (4) begin
      step(1);
      hits += int'(ah1);
    end
    check("alarm_off", hits, 0);
    alarm_en = 1'b1; run = 1'b0;
    do_load(7, 30, 0);
    check("alarm_on_load", {ah1, ah4}, 2'b00);

    // 12/24-hour display
    for (int i = 0; i < 3; i++) begin
      do_load(tab_h[i], tab_m[i], 0);
      mode_12h = 1'b1;
      #1 check("disp12", {pm4, d4}, {1'(tab_pm[i]), 5'(tab_d[i])});
      mode_12h = 1'b0;
      #1 check("disp24", {pm4, d4, h4}, {1'(tab_pm[i]), 5'(tab_h[i]), 5'(tab_h[i])});
    end

    // run/stop keeps prescaler phase (time is 13:05:00, prescaler 0)
    run = 1'b1;
    step(6);
    check("rs_before", {h4, m4, s4}, {5'd13, 6'd5, 6'd1});
    run = 1'b0;
    step(10);
    check("rs_frozen_u4", {h4, m4, s4}, {5'd13, 6'd5, 6'd1});
    check("rs_frozen_u1", {h1, m1, s1}, {5'd13, 6'd5, 6'd6});
    run = 1'b1;
    step(1);
    check("rs_phase", {s4, st4}, {6'd1, 1'b0});
    step(1);
    check("rs_resume", {s4, st4}, {6'd2, 1'b1});

    // asynchronous reset lands between clock edges
    step(2);
    rst = 1'b1;
    #1 check("async_rst", {h4, m4, s4, st4, h1, m1, s1, st1}, '0);
    step(2);
    rst = 1'b0;

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      run = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 49) == 0) mode_12h = ~mode_12h;
      if ($urandom_range(0, 29) == 0) alarm_en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 24) == 0) begin
        load_h = 5'($urandom_range(0, 25));
        load_m = 6'($urandom_range(55, 61));
        load_s = 6'($urandom_range(40, 63));
        alarm_h = ($urandom_range(0, 1) == 0) ? load_h : 5'($urandom_range(0, 24));
        alarm_m = 6'((int'(load_m) + 1) % 60);
        load = 1'b1;
      end else begin
        load = 1'b0;
      end
      step(1);
    end
    load = 1'b0;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
